// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Bundles every non-clock signal of the MIPS decode stage.
//   Fetch side : in_valid, pc_in, insn_in, stall
//   WB side    : wb_en, wb_addr, wb_data
//   ID/EX side : valid, pc, insn, rsData, rtData, imm, ALUOp, dest,
//                reg_write, illegal
//   The slave modport is taken by decode_stage. The master modport is
//   taken by whatever drives fetch/WB and consumes ID/EX.
interface decode_stage_if;
  logic        in_valid;
  logic [31:0] pc_in;
  logic [31:0] insn_in;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        valid;
  logic [31:0] pc;
  logic [31:0] insn;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] imm;
  logic [5:0]  ALUOp;
  logic [4:0]  dest;
  logic        reg_write;
  logic        illegal;

  modport slave (
    input  in_valid, pc_in, insn_in, stall, wb_en, wb_addr, wb_data,
    output valid, pc, insn, rsData, rtData, imm, ALUOp, dest, reg_write, illegal
  );

  modport master (
    output in_valid, pc_in, insn_in, stall, wb_en, wb_addr, wb_data,
    input  valid, pc, insn, rsData, rtData, imm, ALUOp, dest, reg_write, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
//   Instruction-decode stage of a 5-stage MIPS pipeline. Owns the 32x32
//   register file, decodes the fetched instruction into ALUOp / extended
//   immediate / destination, and registers everything into the ID/EX
//   pipeline register one cycle later.
//   Ports:
//     clock : system clock, all state changes on posedge
//     reset : synchronous active-high reset
//     bus   : decode_stage_if.slave (fetch inputs, WB write port, ID/EX outputs)
//   Parameters:
//     NUM_REGS : register-file depth (index 0 reads as zero)
//     RESET_PC : pc value held in ID/EX after reset
module decode_stage #(
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset,
  decode_stage_if.slave bus
);

  localparam logic [5:0] ALU_NOP  = 6'b000000;
  localparam logic [5:0] ALU_ADD  = 6'b000001;
  localparam logic [5:0] ALU_ADDU = 6'b000010;
  localparam logic [5:0] ALU_SUB  = 6'b000011;
  localparam logic [5:0] ALU_SUBU = 6'b000100;
  localparam logic [5:0] ALU_AND  = 6'b000101;
  localparam logic [5:0] ALU_OR   = 6'b000110;
  localparam logic [5:0] ALU_XOR  = 6'b000111;
  localparam logic [5:0] ALU_NOR  = 6'b001000;
  localparam logic [5:0] ALU_SLT  = 6'b001001;
  localparam logic [5:0] ALU_SLTU = 6'b001010;
  localparam logic [5:0] ALU_SLL  = 6'b001011;
  localparam logic [5:0] ALU_SRL  = 6'b001100;
  localparam logic [5:0] ALU_SRA  = 6'b001101;
  localparam logic [5:0] ALU_LUI  = 6'b001110;

  logic [31:0] reg_file [NUM_REGS];

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] sign_imm;
  logic [31:0] zero_imm;

  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic [5:0]  dec_alu_op;
  logic [31:0] dec_imm;
  logic [4:0]  dec_dest;
  logic        dec_write;
  logic        dec_illegal;
  logic        wb_live;

  assign opcode   = bus.insn_in[31:26];
  assign rs       = bus.insn_in[25:21];
  assign rt       = bus.insn_in[20:16];
  assign rd       = bus.insn_in[15:11];
  assign funct    = bus.insn_in[5:0];
  assign sign_imm = {{16{bus.insn_in[15]}}, bus.insn_in[15:0]};
  assign zero_imm = {16'h0000, bus.insn_in[15:0]};
  assign wb_live  = bus.wb_en && (bus.wb_addr != 5'd0);

  // Register file: writes from WB land regardless of stall; r0 is never written.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file[i] <= '0;
      end
    end else if (wb_live) begin
      reg_file[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Operand read with same-cycle bypass so a value being written this edge
  // is seen by the instruction decoding in the same cycle.
  always_comb begin
    rs_value = reg_file[rs];
    rt_value = reg_file[rt];
    if (wb_live && (bus.wb_addr == rs)) rs_value = bus.wb_data;
    if (wb_live && (bus.wb_addr == rt)) rt_value = bus.wb_data;
    if (rs == 5'd0) rs_value = '0;
    if (rt == 5'd0) rt_value = '0;
  end

  // Instruction decode. Unsupported encodings become an illegal NOP with no
  // destination; a destination of r0 never requests a register write.
  always_comb begin
    dec_alu_op  = ALU_NOP;
    dec_imm     = '0;
    dec_dest    = '0;
    dec_write   = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      6'b000000: begin
        dec_dest  = rd;
        dec_write = 1'b1;
        case (funct)
          6'b100000: dec_alu_op = ALU_ADD;
          6'b100001: dec_alu_op = ALU_ADDU;
          6'b100010: dec_alu_op = ALU_SUB;
          6'b100011: dec_alu_op = ALU_SUBU;
          6'b100100: dec_alu_op = ALU_AND;
          6'b100101: dec_alu_op = ALU_OR;
          6'b100110: dec_alu_op = ALU_XOR;
          6'b100111: dec_alu_op = ALU_NOR;
          6'b101010: dec_alu_op = ALU_SLT;
          6'b101011: dec_alu_op = ALU_SLTU;
          6'b000000: dec_alu_op = ALU_SLL;
          6'b000010: dec_alu_op = ALU_SRL;
          6'b000011: dec_alu_op = ALU_SRA;
          default: begin
            dec_dest    = '0;
            dec_write   = 1'b0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      6'b001000: begin dec_alu_op = ALU_ADD;  dec_imm = sign_imm; dec_dest = rt; dec_write = 1'b1; end
      6'b001001: begin dec_alu_op = ALU_ADDU; dec_imm = sign_imm; dec_dest = rt; dec_write = 1'b1; end
      6'b001010: begin dec_alu_op = ALU_SLT;  dec_imm = sign_imm; dec_dest = rt; dec_write = 1'b1; end
      6'b001011: begin dec_alu_op = ALU_SLTU; dec_imm = sign_imm; dec_dest = rt; dec_write = 1'b1; end
      6'b001100: begin dec_alu_op = ALU_AND;  dec_imm = zero_imm; dec_dest = rt; dec_write = 1'b1; end
      6'b001101: begin dec_alu_op = ALU_OR;   dec_imm = zero_imm; dec_dest = rt; dec_write = 1'b1; end
      6'b001110: begin dec_alu_op = ALU_XOR;  dec_imm = zero_imm; dec_dest = rt; dec_write = 1'b1; end
      6'b001111: begin dec_alu_op = ALU_LUI;  dec_imm = {bus.insn_in[15:0], 16'h0000}; dec_dest = rt; dec_write = 1'b1; end
      6'b100011: begin dec_alu_op = ALU_ADDU; dec_imm = sign_imm; dec_dest = rt; dec_write = 1'b1; end
      6'b101011: begin dec_alu_op = ALU_ADDU; dec_imm = sign_imm; dec_dest = rt; dec_write = 1'b0; end
      default:   dec_illegal = 1'b1;
    endcase
    if (dec_dest == 5'd0) dec_write = 1'b0;
  end

  // ID/EX register. A stall holds everything except that a WB write to a
  // source of the held instruction refreshes that operand, so execute never
  // sees a stale value once the stall releases.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.valid     <= 1'b0;
      bus.pc        <= RESET_PC;
      bus.insn      <= '0;
      bus.rsData    <= '0;
      bus.rtData    <= '0;
      bus.imm       <= '0;
      bus.ALUOp     <= ALU_NOP;
      bus.dest      <= '0;
      bus.reg_write <= 1'b0;
      bus.illegal   <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        bus.valid     <= 1'b1;
        bus.pc        <= bus.pc_in;
        bus.insn      <= bus.insn_in;
        bus.rsData    <= rs_value;
        bus.rtData    <= rt_value;
        bus.imm       <= dec_imm;
        bus.ALUOp     <= dec_alu_op;
        bus.dest      <= dec_dest;
        bus.reg_write <= dec_write;
        bus.illegal   <= dec_illegal;
      end else begin
        bus.valid     <= 1'b0;
        bus.pc        <= '0;
        bus.insn      <= '0;
        bus.rsData    <= '0;
        bus.rtData    <= '0;
        bus.imm       <= '0;
        bus.ALUOp     <= ALU_NOP;
        bus.dest      <= '0;
        bus.reg_write <= 1'b0;
        bus.illegal   <= 1'b0;
      end
    end else begin
      if (wb_live && (bus.wb_addr == bus.insn[25:21])) bus.rsData <= bus.wb_data;
      if (wb_live && (bus.wb_addr == bus.insn[20:16])) bus.rtData <= bus.wb_data;
    end
  end

endmodule
